// File: rtl/ycbridge.sv
// ycbridge: valid/ready word in, dual-rail drive into the top row of a yellow-cell
// array, per-column completion capture, result out, then return-to-empty.
module ycbridge #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_data,
  output logic           busy,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [2*N-1:0] col_out,
  input  logic [2*N-1:0] col_back
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_RESPOND,
    S_RETURN,
    S_ERROR
  } state_t;

  state_t state_q, state_n;

  logic [W2-1:0] sync1, sb;
  logic [N-1:0]  done, done_n;
  logic [N-1:0]  res_data_n;
  logic [W2-1:0] col_out_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    err_code_n;
  logic          in_ready_n, res_valid_n, busy_n, err_n;

  logic [N-1:0]  col_full;
  logic [N-1:0]  col_bad;
  logic          any_bad;
  logic          sb_empty;
  logic          sync1_empty;
  logic          to_hit;

  // Two-flop synchronizer on the asynchronous return rails
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sb    <= '0;
    end else begin
      sync1 <= col_back;
      sb    <= sync1;
    end
  end

  // Per-column decode of synchronized rails
  always_comb begin
    col_full = '0;
    col_bad  = '0;
    for (int i = 0; i < int'(N); i++) begin
      col_full[i] = |sb[2*i +: 2];
      col_bad[i]  = &sb[2*i +: 2];
    end
  end

  assign any_bad     = |col_bad;
  assign sb_empty    = ~|sb;
  assign sync1_empty = ~|sync1;
  assign to_hit      = (cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // Next-state and next-register values
  always_comb begin
    state_n    = state_q;
    col_out_n  = col_out;
    done_n     = done;
    res_data_n = res_data;
    cnt_n      = cnt;
    err_code_n = err_code;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < int'(N); i++) begin
            col_out_n[2*i +: 2] = in_data[i] ? 2'b10 : 2'b01;
          end
          done_n  = '0;
          cnt_n   = '0;
          state_n = S_DRIVE;
        end
      end

      S_DRIVE: begin
        cnt_n = cnt + CW'(1);
        for (int i = 0; i < int'(N); i++) begin
          if (!done[i] && col_full[i]) begin
            res_data_n[i] = sb[2*i+1];
            done_n[i]     = 1'b1;
          end
        end
        if (any_bad) begin
          state_n    = S_ERROR;
          err_code_n = ERR_ILLEGAL;
          col_out_n  = '0;
          cnt_n      = '0;
        end else if (to_hit) begin
          state_n    = S_ERROR;
          err_code_n = ERR_TIMEOUT;
          col_out_n  = '0;
          cnt_n      = '0;
        end else if (&done_n) begin
          state_n = S_RESPOND;
          cnt_n   = '0;
        end
      end

      S_RESPOND: begin
        if (res_valid && res_ready) begin
          col_out_n = '0;
          cnt_n     = '0;
          state_n   = S_RETURN;
        end
      end

      S_RETURN: begin
        cnt_n = cnt + CW'(1);
        if (any_bad) begin
          state_n    = S_ERROR;
          err_code_n = ERR_ILLEGAL;
          col_out_n  = '0;
          cnt_n      = '0;
        end else if (to_hit) begin
          state_n    = S_ERROR;
          err_code_n = ERR_TIMEOUT;
          col_out_n  = '0;
          cnt_n      = '0;
        end else if (sb_empty) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end

      S_ERROR: begin
        col_out_n = '0;
      end

      default: begin
        state_n   = S_ERROR;
        col_out_n = '0;
      end
    endcase

    // sb takes sync1 at the edge, so this tracks "all sb empty" while idle
    in_ready_n  = (state_n == S_IDLE) && sync1_empty;
    // One cycle after entering RESPOND, held until the handshake
    res_valid_n = (state_q == S_RESPOND) && (state_n == S_RESPOND);
    busy_n      = (state_n != S_IDLE);
    err_n       = (state_n == S_ERROR);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_out   <= '0;
      res_data  <= '0;
      done      <= '0;
      cnt       <= '0;
      err_code  <= 2'b00;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      col_out   <= col_out_n;
      res_data  <= res_data_n;
      done      <= done_n;
      cnt       <= cnt_n;
      err_code  <= err_code_n;
      in_ready  <= in_ready_n;
      res_valid <= res_valid_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_ycbridge.sv
// Directed bench for ycbridge: loopback, skew, back-pressure, timeout, illegal, reset.
module tb_ycbridge;

  logic        clk;
  logic        reset;

  logic        in_valid, in_ready, res_valid, res_ready, busy, err;
  logic [7:0]  in_data, res_data;
  logic [1:0]  err_code;
  logic [15:0] col_out, col_back, lb_mask, lb_force;

  logic        in_valid2, in_ready2, res_valid2, res_ready2, busy2, err2;
  logic [7:0]  in_data2, res_data2;
  logic [1:0]  err_code2;
  logic [15:0] col_out2, col_back2, lb_mask2;

  int total = 0;
  int bad   = 0;
  int n;
  logic flag;

  ycbridge #(.N(8), .TIMEOUT(1023)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err), .err_code(err_code),
    .col_out(col_out), .col_back(col_back)
  );

  ycbridge #(.N(8), .TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2),
    .busy(busy2), .err(err2), .err_code(err_code2),
    .col_out(col_out2), .col_back(col_back2)
  );

  // Array model: instantaneous loopback with per-rail masking and forcing
  assign col_back  = (col_out & lb_mask) | lb_force;
  assign col_back2 = col_out2 & lb_mask2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_rv(input int lim, output int cnt);
    cnt = 0;
    while (!res_valid && cnt < lim) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_ir(input int lim);
    int c;
    c = 0;
    while (!in_ready && c < lim) begin
      tick();
      c++;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b1;
    lb_mask = 16'hFFFF; lb_force = 16'h0000;
    in_valid2 = 1'b0; in_data2 = 8'h00; res_ready2 = 1'b1;
    lb_mask2 = 16'hFFFC;

    // Reset values
    #2;
    chk("rst_col_out", 32'(col_out), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data", 32'(res_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_err_code", 32'(err_code), 32'h0);
    #10;
    reset = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'h1);
    chk("idle_in_ready2", 32'(in_ready2), 32'h1);

    // Timeout: column 0 of the TIMEOUT=16 instance never returns
    in_valid2 = 1'b1; in_data2 = 8'h01;
    tick();
    chk("to_busy", 32'(busy2), 32'h1);
    chk("to_col_out", 32'(col_out2), 32'h5556);
    flag = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      flag = flag | err2;
    end
    chk("to_no_early_err", 32'(flag), 32'h0);
    tick();
    chk("to_err", 32'(err2), 32'h1);
    chk("to_err_code", 32'(err_code2), 32'h1);
    chk("to_col_out_zero", 32'(col_out2), 32'h0);
    chk("to_in_ready", 32'(in_ready2), 32'h0);
    chk("to_busy_err", 32'(busy2), 32'h1);
    for (int k = 0; k < 5; k++) tick();
    chk("to_err_held", 32'(err2), 32'h1);
    chk("to_in_ready_held", 32'(in_ready2), 32'h0);
    in_valid2 = 1'b0;

    // Loopback 0xA5
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    chk("lb_busy", 32'(busy), 32'h1);
    chk("lb_in_ready", 32'(in_ready), 32'h0);
    chk("lb_col_out", 32'(col_out), 32'h9966);
    flag = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      flag = flag | res_valid;
    end
    chk("lb_no_early_valid", 32'(flag), 32'h0);
    tick();
    chk("lb_res_valid", 32'(res_valid), 32'h1);
    chk("lb_res_data", 32'(res_data), 32'hA5);
    tick();
    chk("lb_valid_drop", 32'(res_valid), 32'h0);
    chk("lb_col_empty", 32'(col_out), 32'h0);
    tick();
    tick();
    chk("lb_ready_wait", 32'(in_ready), 32'h0);
    tick();
    chk("lb_ready_back", 32'(in_ready), 32'h1);
    chk("lb_busy_idle", 32'(busy), 32'h0);

    // Skewed return: column 3 late by 20 cycles
    lb_mask = 16'hFF3F;
    in_valid = 1'b1; in_data = 8'h08;
    tick();
    in_valid = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      flag = flag | res_valid;
    end
    chk("sk_no_early_valid", 32'(flag), 32'h0);
    lb_mask = 16'hFFFF;
    wait_rv(10, n);
    chk("sk_latency", 32'(n), 32'd4);
    chk("sk_res_data", 32'(res_data), 32'h08);
    wait_ir(20);
    chk("sk_ready_back", 32'(in_ready), 32'h1);

    // Back-pressure: hold res_ready low for 50 cycles
    res_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0; in_data = 8'hFF;
    wait_rv(10, n);
    chk("bp_valid", 32'(res_valid), 32'h1);
    flag = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      flag = flag & res_valid & (res_data == 8'h3C) & (col_out == 16'h5AA5) & ~err;
    end
    chk("bp_stable", 32'(flag), 32'h1);
    chk("bp_err_code", 32'(err_code), 32'h0);
    res_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(res_valid), 32'h0);
    chk("bp_col_empty", 32'(col_out), 32'h0);
    chk("bp_data_held", 32'(res_data), 32'h3C);
    wait_ir(20);
    chk("bp_ready_back", 32'(in_ready), 32'h1);

    // Illegal code on column 2 during DRIVE
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    lb_force = 16'h0030;
    tick();
    tick();
    chk("il_no_early_err", 32'(err), 32'h0);
    tick();
    chk("il_err", 32'(err), 32'h1);
    chk("il_err_code", 32'(err_code), 32'h2);
    chk("il_col_out", 32'(col_out), 32'h0);
    chk("il_in_ready", 32'(in_ready), 32'h0);
    chk("il_res_valid", 32'(res_valid), 32'h0);
    lb_force = 16'h0000;

    // Clear the error, then reset mid-DRIVE
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
    chk("rc_err_clear", 32'(err), 32'h0);
    chk("rc_in_ready", 32'(in_ready), 32'h1);
    lb_mask = 16'hFFFC;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rm_busy_before", 32'(busy), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_col_out", 32'(col_out), 32'h0);
    chk("rm_res_valid", 32'(res_valid), 32'h0);
    chk("rm_busy", 32'(busy), 32'h0);
    #2;
    reset = 1'b0;
    lb_mask = 16'hFFFF;
    wait_ir(10);
    chk("rm_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    chk("rm_col_out_ff", 32'(col_out), 32'hAAAA);
    wait_rv(10, n);
    chk("rm_latency", 32'(n), 32'd4);
    chk("rm_res_data", 32'(res_data), 32'hFF);
    wait_ir(20);
    chk("rm_ready_back", 32'(in_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
